// File: rtl/lsu_pkg.sv
// Shared types and helpers for the execute-stage load/store unit.
package lsu_pkg;

  localparam logic [1:0] LSU_SIZE_1 = 2'd0;
  localparam logic [1:0] LSU_SIZE_2 = 2'd1;
  localparam logic [1:0] LSU_SIZE_4 = 2'd2;
  localparam logic [1:0] LSU_SIZE_8 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    RDW,
    RESP
  } lsu_state_t;

  // Number of bytes moved by an access of the given size code.
  function automatic int size_bytes(input logic [1:0] size);
    int nb;
    nb = 8;
    case (size)
      LSU_SIZE_1: nb = 1;
      LSU_SIZE_2: nb = 2;
      LSU_SIZE_4: nb = 4;
      LSU_SIZE_8: nb = 8;
      default:    nb = 8;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/execute_lsu_if.sv
// Request, data-memory and response signals of the load/store unit.
interface execute_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 64,
  parameter int DATA_W = 64,
  parameter int DISP_W = 32,
  parameter int RD_W   = 4
);
  localparam int B = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [REG_W-1:0]  req_base;
  logic [DISP_W-1:0] req_disp;
  logic [REG_W-1:0]  req_st_data;
  logic [RD_W-1:0]   req_rd;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [B-1:0]      mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              resp_valid;
  logic [RD_W-1:0]   resp_rd;
  logic [REG_W-1:0]  resp_data;

  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_base, req_disp,
           req_st_data, req_rd, mem_rdata,
    output req_ready, mem_addr, mem_re, mem_we, mem_wdata,
           resp_valid, resp_rd, resp_data
  );

  modport master (
    output req_valid, req_store, req_size, req_signed, req_base, req_disp,
           req_st_data, req_rd, mem_rdata,
    input  req_ready, mem_addr, mem_re, mem_we, mem_wdata,
           resp_valid, resp_rd, resp_data
  );

endinterface

// File: rtl/execute_lsu_align.sv
// Byte-lane steering for stores and merge/extension for loads.
module execute_lsu_align
  import lsu_pkg::*;
#(
  parameter int  REG_W  = 64,
  parameter int  DATA_W = 64,
  localparam int B      = DATA_W / 8,
  localparam int OW     = $clog2(B)
) (
  input  logic [OW-1:0]     off_i,
  input  logic [1:0]        size_i,
  input  logic              sgn_i,
  input  logic [REG_W-1:0]  st_data_i,
  input  logic [DATA_W-1:0] rdata0_i,
  input  logic [DATA_W-1:0] rdata1_i,
  output logic [B-1:0]      we0_o,
  output logic [B-1:0]      we1_o,
  output logic [DATA_W-1:0] wdata0_o,
  output logic [DATA_W-1:0] wdata1_o,
  output logic [REG_W-1:0]  ld_result_o
);
  int                  n;
  logic [B-1:0]        mask;
  logic [2*B-1:0]      mask_sh;
  logic [2*DATA_W-1:0] st_sh;
  logic [REG_W-1:0]    r;
  logic                sbit;

  // Shift the byte mask and store data across a two-word window; the upper word is the spill.
  always_comb begin
    n = size_bytes(size_i);
    for (int i = 0; i < B; i++) mask[i] = (i < n);
    mask_sh  = {{B{1'b0}}, mask} << off_i;
    st_sh    = {{(2*DATA_W-REG_W){1'b0}}, st_data_i} << {off_i, 3'b000};
    we0_o    = mask_sh[B-1:0];
    we1_o    = mask_sh[2*B-1:B];
    wdata0_o = st_sh[DATA_W-1:0];
    wdata1_o = st_sh[2*DATA_W-1:DATA_W];
  end

  // Right-align the accessed bytes from both words, then sign- or zero-extend.
  always_comb begin
    r    = REG_W'({rdata1_i, rdata0_i} >> {off_i, 3'b000});
    sbit = r[REG_W-1];
    case (size_i)
      LSU_SIZE_1: sbit = r[7];
      LSU_SIZE_2: sbit = r[15];
      LSU_SIZE_4: sbit = r[31];
      default:    sbit = r[REG_W-1];
    endcase
    for (int i = 0; i < REG_W; i++) ld_result_o[i] = (i < 8*n) ? r[i] : (sgn_i & sbit);
  end

endmodule

// File: rtl/execute_lsu.sv
// Execute-stage load/store unit: effective address, split accesses, load merge.
//
// state | meaning
// IDLE  | waiting for a request, ready
// ACC0  | memory cycle on the first word
// ACC1  | memory cycle on the following word (straddling access)
// RDW   | last read word arrives, result is formed
// RESP  | load result presented, ready for the next request
module execute_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 64,
  parameter int DATA_W = 64,
  parameter int DISP_W = 32,
  parameter int RD_W   = 4
) (
  input  logic         clk,
  input  logic         rstn,
  execute_lsu_if.slave bus
);
  localparam int B  = DATA_W / 8;
  localparam int OW = $clog2(B);
  localparam int WA = ADDR_W - OW;

  lsu_state_t        state_q, state_d;
  logic              store_q, store_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [OW-1:0]     off_q, off_d;
  logic [WA-1:0]     w0_q, w0_d;
  logic              split_q, split_d;
  logic [REG_W-1:0]  st_q, st_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0] rdata0_q;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d;
  logic [B-1:0]      mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [RD_W-1:0]   resp_rd_q, resp_rd_d;
  logic [REG_W-1:0]  resp_data_q, resp_data_d;

  logic              req_ready, accept, split_c;
  logic [DISP_W-1:0] disp_c;
  logic [ADDR_W-1:0] ea_c;
  logic [DATA_W-1:0] rdata0_sel;
  logic [B-1:0]      we0, we1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [REG_W-1:0]  ld_result;

  assign req_ready  = rstn && (state_q == IDLE || state_q == RESP);
  assign accept     = bus.req_valid && req_ready;
  assign disp_c     = bus.req_disp;
  assign ea_c       = ADDR_W'(bus.req_base) + ADDR_W'($signed(disp_c));
  assign split_c    = (int'(ea_c[OW-1:0]) + size_bytes(bus.req_size)) > B;
  // The first word of a split load was captured during ACC1; otherwise it is on the bus now.
  assign rdata0_sel = split_q ? rdata0_q : bus.mem_rdata;

  execute_lsu_align #(
    .REG_W (REG_W),
    .DATA_W(DATA_W)
  ) u_align (
    .off_i      (off_d),
    .size_i     (size_d),
    .sgn_i      (sgn_d),
    .st_data_i  (st_d),
    .rdata0_i   (rdata0_sel),
    .rdata1_i   (bus.mem_rdata),
    .we0_o      (we0),
    .we1_o      (we1),
    .wdata0_o   (wdata0),
    .wdata1_o   (wdata1),
    .ld_result_o(ld_result)
  );

  // Next state and request latching.
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    w0_d    = w0_q;
    split_d = split_q;
    st_d    = st_q;
    rd_d    = rd_q;
    if (accept) begin
      store_d = bus.req_store;
      size_d  = bus.req_size;
      sgn_d   = bus.req_signed;
      off_d   = ea_c[OW-1:0];
      w0_d    = ea_c[ADDR_W-1:OW];
      split_d = split_c;
      st_d    = bus.req_st_data;
      rd_d    = bus.req_rd;
    end
    case (state_q)
      IDLE:    if (accept) state_d = ACC0;
      ACC0:    state_d = split_q ? ACC1 : (store_q ? IDLE : RDW);
      ACC1:    state_d = store_q ? IDLE : RDW;
      RDW:     state_d = RESP;
      RESP:    state_d = accept ? ACC0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs for the state being entered, so they can be registered.
  always_comb begin
    mem_addr_d   = '0;
    mem_re_d     = 1'b0;
    mem_we_d     = '0;
    mem_wdata_d  = '0;
    resp_valid_d = 1'b0;
    resp_rd_d    = '0;
    resp_data_d  = '0;
    case (state_d)
      ACC0: begin
        mem_addr_d = {{OW{1'b0}}, w0_d};
        if (store_d) begin
          mem_we_d    = we0;
          mem_wdata_d = wdata0;
        end else begin
          mem_re_d = 1'b1;
        end
      end
      ACC1: begin
        mem_addr_d = {{OW{1'b0}}, w0_d + WA'(1)};
        if (store_d) begin
          mem_we_d    = we1;
          mem_wdata_d = wdata1;
        end else begin
          mem_re_d = 1'b1;
        end
      end
      RESP: begin
        resp_valid_d = 1'b1;
        resp_rd_d    = rd_d;
        resp_data_d  = ld_result;
      end
      default: ;
    endcase
  end

  // State, latched request and registered outputs; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      size_q       <= '0;
      sgn_q        <= 1'b0;
      off_q        <= '0;
      w0_q         <= '0;
      split_q      <= 1'b0;
      st_q         <= '0;
      rd_q         <= '0;
      rdata0_q     <= '0;
      mem_addr_q   <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      off_q        <= off_d;
      w0_q         <= w0_d;
      split_q      <= split_d;
      st_q         <= st_d;
      rd_q         <= rd_d;
      if (state_q == ACC1) rdata0_q <= bus.mem_rdata;
      mem_addr_q   <= mem_addr_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_data  = resp_data_q;

endmodule

// File: tb/tb_execute_lsu.sv
// Scoreboard bench for execute_lsu: directed requests push expected memory
// cycles and responses; a negedge monitor pops and compares them.
module tb_execute_lsu;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        re;
    logic [7:0]  we;
    logic [63:0] wdata;
  } mem_exp_t;

  typedef struct {
    int          cyc;
    logic [3:0]  rd;
    logic [63:0] data;
  } resp_exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  mem_exp_t    mem_q[$];
  resp_exp_t   resp_q[$];
  logic [63:0] mem [logic [31:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  execute_lsu_if bus ();

  execute_lsu dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  task automatic check(input string name, input logic ok, input string detail);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic logic [63:0] bytemask(input logic [7:0] we);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{we[b]}};
    return m;
  endfunction

  // Word memory: read data one cycle after mem_re, byte-enabled writes.
  always @(posedge clk) begin
    logic [63:0] w;
    if (bus.mem_re) bus.mem_rdata <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 64'h0;
    if (bus.mem_we != 8'h0) begin
      w = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 64'h0;
      for (int b = 0; b < 8; b++)
        if (bus.mem_we[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
      mem[bus.mem_addr] = w;
    end
  end

  // Monitor: every memory cycle and every response must match the next expectation.
  always @(negedge clk) begin
    mem_exp_t    me;
    resp_exp_t   rr;
    logic [63:0] bm;
    if (bus.mem_re || bus.mem_we != 8'h0) begin
      if (mem_q.size() == 0) begin
        check("mem_unexpected", 1'b0, $sformatf("cyc=%0d addr=%h re=%b we=%h seen, none required",
              cyc, bus.mem_addr, bus.mem_re, bus.mem_we));
      end else begin
        me = mem_q.pop_front();
        bm = bytemask(me.we);
        check("mem_access",
              cyc == me.cyc && bus.mem_addr == me.addr && bus.mem_re == me.re &&
              bus.mem_we == me.we && (bus.mem_wdata & bm) == (me.wdata & bm),
              $sformatf("got cyc=%0d addr=%h re=%b we=%h wdata=%h, want cyc=%0d addr=%h re=%b we=%h wdata=%h",
                        cyc, bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata & bm,
                        me.cyc, me.addr, me.re, me.we, me.wdata & bm));
      end
    end
    if (bus.resp_valid) begin
      if (resp_q.size() == 0) begin
        check("resp_unexpected", 1'b0, $sformatf("cyc=%0d rd=%h data=%h seen, none required",
              cyc, bus.resp_rd, bus.resp_data));
      end else begin
        rr = resp_q.pop_front();
        check("resp", cyc == rr.cyc && bus.resp_rd == rr.rd && bus.resp_data == rr.data,
              $sformatf("got cyc=%0d rd=%h data=%h, want cyc=%0d rd=%h data=%h",
                        cyc, bus.resp_rd, bus.resp_data, rr.cyc, rr.rd, rr.data));
      end
    end
  end

  // Offer a request (called at a negedge), hold it until accepted, push expectations.
  task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [63:0] base, input logic [31:0] disp,
                       input logic [63:0] sd, input logic [3:0] rd, input logic split,
                       input logic [31:0] a0, input logic [7:0] we0, input logic [63:0] wd0,
                       input logic [31:0] a1, input logic [7:0] we1, input logic [63:0] wd1,
                       input logic has_resp, input logic [63:0] rdata, output int acc);
    int waited;
    waited          = 0;
    bus.req_valid   = 1'b1;
    bus.req_store   = st;
    bus.req_size    = sz;
    bus.req_signed  = sg;
    bus.req_base    = base;
    bus.req_disp    = disp;
    bus.req_st_data = sd;
    bus.req_rd      = rd;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 1'b0, "req_ready stayed 0 for 50 cycles, want 1");
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    mem_q.push_back('{acc + 1, a0, !st, st ? we0 : 8'h0, wd0});
    if (split) mem_q.push_back('{acc + 2, a1, !st, st ? we1 : 8'h0, wd1});
    if (has_resp && !st) resp_q.push_back('{acc + (split ? 4 : 3), rd, rdata});
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, bus.mem_addr == 32'h0 && !bus.mem_re && bus.mem_we == 8'h0 &&
          bus.mem_wdata == 64'h0 && !bus.resp_valid && bus.resp_rd == 4'h0 && bus.resp_data == 64'h0,
          $sformatf("addr=%h re=%b we=%h wdata=%h rv=%b rd=%h data=%h, want all 0",
                    bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata,
                    bus.resp_valid, bus.resp_rd, bus.resp_data));
  endtask

  initial begin
    int a, b;
    rstn            = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_store   = 1'b0;
    bus.req_size    = 2'd0;
    bus.req_signed  = 1'b0;
    bus.req_base    = 64'h0;
    bus.req_disp    = 32'h0;
    bus.req_st_data = 64'h0;
    bus.req_rd      = 4'h0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    check("reset_ready_low", bus.req_ready == 1'b0, $sformatf("req_ready=%b, want 0", bus.req_ready));
    rstn = 1'b1;
    #1;
    check("ready_after_reset", bus.req_ready == 1'b1, $sformatf("req_ready=%b, want 1", bus.req_ready));
    @(negedge clk);

    // Split load cut by reset during its second memory cycle: no response ever.
    mem[32'h200] = 64'hAABBCCDD_EEFF0011;
    mem[32'h201] = 64'h0000_0000_0000_0080;
    issue(0, 2'd2, 1, 64'h1005, 32'h0, 64'h0, 4'h1, 1,
          32'h200, 8'h0, 64'h0, 32'h201, 8'h0, 64'h0, 0, 64'h0, a);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset_mid_split");
    check("reset_mid_ready_low", bus.req_ready == 1'b0, $sformatf("req_ready=%b, want 0", bus.req_ready));
    rstn = 1'b1;
    #1;
    check("ready_after_mid_reset", bus.req_ready == 1'b1, $sformatf("req_ready=%b, want 1", bus.req_ready));
    repeat (4) @(negedge clk);

    // Aligned doubleword load, n = B with off = 0 is a single access.
    mem[32'h201] = 64'h1122334455667788;
    issue(0, 2'd3, 0, 64'h1000, 32'h8, 64'h0, 4'h2, 0,
          32'h201, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0, 1, 64'h1122334455667788, a);
    repeat (4) @(negedge clk);

    // Split signed word load.
    mem[32'h201] = 64'h0000_0000_0000_0080;
    issue(0, 2'd2, 1, 64'h1005, 32'h0, 64'h0, 4'h3, 1,
          32'h200, 8'h0, 64'h0, 32'h201, 8'h0, 64'h0, 1, 64'hFFFFFFFF_80AABBCC, a);
    repeat (5) @(negedge clk);

    // Split store with negative displacement, then read it back as soon as ready.
    issue(1, 2'd2, 0, 64'h0F, 32'hFFFF_FFFF, 64'h11223344, 4'h0, 1,
          32'h1, 8'hC0, 64'h3344_0000_0000_0000, 32'h2, 8'h03, 64'h0000_0000_0000_1122, 0, 64'h0, a);
    issue(0, 2'd2, 0, 64'h0E, 32'h0, 64'h0, 4'h4, 1,
          32'h1, 8'h0, 64'h0, 32'h2, 8'h0, 64'h0, 1, 64'h0000_0000_1122_3344, b);
    check("split_store_ready", b == a + 3, $sformatf("next accept at %0d, want %0d", b, a + 3));
    repeat (6) @(negedge clk);

    // Aligned byte store with junk upper data, then signed byte load.
    issue(1, 2'd0, 0, 64'h2003, 32'h0, 64'hFFFF_FFFF_FFFF_FFAB, 4'h0, 0,
          32'h400, 8'h08, 64'h0000_0000_AB00_0000, 32'h0, 8'h0, 64'h0, 0, 64'h0, a);
    issue(0, 2'd0, 1, 64'h2000, 32'h3, 64'h0, 4'h5, 0,
          32'h400, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFAB, b);
    check("aligned_store_ready", b == a + 2, $sformatf("next accept at %0d, want %0d", b, a + 2));
    repeat (5) @(negedge clk);

    // Wrap from the top word to word 0; upper base bits are truncated away.
    mem[32'h1FFF_FFFF] = 64'hDDCC_0000_0000_0000;
    mem[32'h0]         = 64'h0000_0000_0000_BBAA;
    issue(0, 2'd2, 0, 64'h1234_5678_0000_0000, 32'hFFFF_FFFE, 64'h0, 4'h6, 1,
          32'h1FFF_FFFF, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0, 1, 64'h0000_0000_BBAA_DDCC, a);
    repeat (6) @(negedge clk);

    // Back-to-back: second load held valid while the first is in flight.
    mem[32'h602] = 64'h0000_0000_0000_8001;
    mem[32'h603] = 64'h0000_0000_CAFE_0000;
    issue(0, 2'd1, 1, 64'h3000, 32'h10, 64'h0, 4'h7, 0,
          32'h602, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_8001, a);
    issue(0, 2'd1, 0, 64'h3000, 32'h1A, 64'h0, 4'h8, 0,
          32'h603, 8'h0, 64'h0, 32'h0, 8'h0, 64'h0, 1, 64'h0000_0000_0000_CAFE, b);
    check("back_to_back_accept", b == a + 3, $sformatf("second accept at %0d, want %0d", b, a + 3));
    repeat (8) @(negedge clk);

    check("mem_queue_drained", mem_q.size() == 0,
          $sformatf("%0d memory cycles still pending, want 0", mem_q.size()));
    check("resp_queue_drained", resp_q.size() == 0,
          $sformatf("%0d responses still pending, want 0", resp_q.size()));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "time limit");
  end

endmodule
